// File: rtl/song_reader_pkg.sv
// Shared encodings for the polyphonic song reader: FSM states, song ROM
// field positions and the fast-seek duration shift.
package song_reader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        ADVANCE = 3'd3,
        PAUSED  = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int ADV_BIT  = 15;
    localparam int NOTE_MSB = 14;
    localparam int NOTE_LSB = 9;
    localparam int DUR_MSB  = 8;
    localparam int DUR_LSB  = 3;

    localparam int SCALE_SHIFT = 2;

endpackage

// File: rtl/song_reader_poly_voice_slot_bank.sv
// Chord accumulator: fills voice slots in order and flags notes that arrive
// with every slot occupied.
module voice_slot_bank #(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         load,
    input  logic                         clear,
    input  logic [NOTE_W-1:0]            note,
    input  logic [DUR_W-1:0]             dur,
    output logic [NUM_VOICES*NOTE_W-1:0] notes,
    output logic [NUM_VOICES*DUR_W-1:0]  durs,
    output logic [NUM_VOICES-1:0]        valid,
    output logic                         drop
);

    localparam int FILL_W = $clog2(NUM_VOICES + 1);

    logic [FILL_W-1:0] fill;
    logic              full;

    assign full = (fill == FILL_W'(NUM_VOICES));
    assign drop = load & full;

    // Clear wins over load so an end-of-song note never survives into the next pass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            notes <= '0;
            durs  <= '0;
            valid <= '0;
            fill  <= '0;
        end else if (clear) begin
            notes <= '0;
            durs  <= '0;
            valid <= '0;
            fill  <= '0;
        end else if (load && !full) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (fill == FILL_W'(i)) begin
                    notes[i*NOTE_W +: NOTE_W] <= note;
                    durs[i*DUR_W +: DUR_W]    <= dur;
                    valid[i]                  <= 1'b1;
                end
            end
            fill <= fill + FILL_W'(1);
        end
    end

endmodule

// File: rtl/song_reader_poly.sv
// Song ROM walker that groups note entries into chords and paces them by beats.
// Define SONG_READER_LOOP_EN to wrap around at the song boundary instead of stopping.
module song_reader_poly #(
    parameter int NUM_VOICES  = 3,
    parameter int NUM_SONGS   = 4,
    parameter int SONG_ADDR_W = 7,
    parameter int NOTE_W      = 6,
    parameter int DUR_W       = 6,
    localparam int SONG_SEL_W = $clog2(NUM_SONGS)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              play,
    input  logic                              beat,
    input  logic                              rewind,
    input  logic                              ff,
    input  logic [SONG_SEL_W-1:0]             song,
    output logic [SONG_SEL_W+SONG_ADDR_W-1:0] rom_addr,
    input  logic [15:0]                       rom_data,
    output logic [NUM_VOICES*NOTE_W-1:0]      notes_out,
    output logic [NUM_VOICES*DUR_W-1:0]       durations_out,
    output logic [NUM_VOICES-1:0]             voice_valid,
    output logic                              new_note,
    output logic                              song_done,
    output logic                              overflow
);

    import song_reader_pkg::*;

    state_t                       state;
    logic [SONG_ADDR_W-1:0]       ptr;
    logic [SONG_ADDR_W-1:0]       ptr_step;
    logic [SONG_SEL_W-1:0]        song_latched;
    logic [DUR_W-1:0]             counter;
    logic [DUR_W-1:0]             dur_scaled;
    logic [NOTE_W-1:0]            rom_note;
    logic                         rom_adv;
    logic                         song_chg;
    logic                         decoding;
    logic                         at_end;
    logic                         slot_load;
    logic                         slot_clear;
    logic                         slot_drop;
    logic [NUM_VOICES*NOTE_W-1:0] slot_notes;
    logic [NUM_VOICES*DUR_W-1:0]  slot_durs;
    logic [NUM_VOICES-1:0]        slot_valid;
    logic                         unused_rom_bits;

    // Seeking shortens durations but never turns a real duration into zero.
    function automatic logic [DUR_W-1:0] scale_dur(input logic [DUR_W-1:0] d, input logic fast);
        logic [DUR_W-1:0] s;
        s = d >> SCALE_SHIFT;
        if (!fast)
            return d;
        if (s == '0 && d != '0)
            return DUR_W'(1);
        return s;
    endfunction

    assign rom_addr        = {song_latched, ptr};
    assign rom_adv         = rom_data[ADV_BIT];
    assign rom_note        = rom_data[NOTE_MSB:NOTE_LSB];
    assign dur_scaled      = scale_dur(rom_data[DUR_MSB:DUR_LSB], rewind | ff);
    assign unused_rom_bits = ^rom_data[DUR_LSB-1:0];

    assign ptr_step   = rewind ? ptr - SONG_ADDR_W'(1) : ptr + SONG_ADDR_W'(1);
    assign at_end     = rewind ? (ptr == '0) : (ptr == '1);
    assign song_chg   = (state != IDLE) && (song != song_latched);
    assign decoding   = (state == DECODE) && play && !song_chg;
    assign slot_load  = decoding && !rom_adv;
    assign slot_clear = song_chg || (decoding && (rom_adv || at_end));

    voice_slot_bank #(
        .NUM_VOICES (NUM_VOICES),
        .NOTE_W     (NOTE_W),
        .DUR_W      (DUR_W)
    ) u_slots (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (slot_load),
        .clear   (slot_clear),
        .note    (rom_note),
        .dur     (dur_scaled),
        .notes   (slot_notes),
        .durs    (slot_durs),
        .valid   (slot_valid),
        .drop    (slot_drop)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            ptr           <= '0;
            song_latched  <= '0;
            counter       <= '0;
            notes_out     <= '0;
            durations_out <= '0;
            voice_valid   <= '0;
            new_note      <= 1'b0;
            song_done     <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            new_note  <= 1'b0;
            song_done <= 1'b0;
            if (song_chg) begin
                state         <= IDLE;
                ptr           <= '0;
                notes_out     <= '0;
                durations_out <= '0;
                voice_valid   <= '0;
                overflow      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        song_latched <= song;
                        if (play)
                            state <= FETCH;
                    end
                    FETCH: begin
                        state <= play ? DECODE : PAUSED;
                    end
                    DECODE: begin
                        if (!play) begin
                            state <= PAUSED;
                        end else begin
                            ptr <= ptr_step;
                            if (rom_adv) begin
                                notes_out     <= slot_notes;
                                durations_out <= slot_durs;
                                voice_valid   <= slot_valid;
                                new_note      <= 1'b1;
                                counter       <= dur_scaled;
                                state         <= (dur_scaled == '0) ? FETCH : ADVANCE;
                            end else begin
                                if (slot_drop)
                                    overflow <= 1'b1;
                                state <= FETCH;
                            end
                            if (at_end) begin
                                song_done <= 1'b1;
`ifdef SONG_READER_LOOP_EN
                                state <= FETCH;
`else
                                ptr   <= '0;
                                state <= DONE;
`endif
                            end
                        end
                    end
                    ADVANCE: begin
                        if (!play) begin
                            state <= PAUSED;
                        end else if (beat) begin
                            counter <= counter - DUR_W'(1);
                            if (counter == DUR_W'(1))
                                state <= FETCH;
                        end
                    end
                    PAUSED: begin
                        if (play)
                            state <= FETCH;
                    end
                    DONE: begin
                        if (!play)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_reader_poly.sv
// Scoreboard bench for song_reader_poly: expected chords are queued by the
// directed stimulus and consumed by a monitor on every new_note pulse.
module tb_song_reader_poly;

    typedef struct packed {
        logic [17:0] n;
        logic [17:0] d;
        logic [2:0]  v;
    } chord_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        play;
    logic        beat;
    logic        rewind;
    logic        ff;
    logic [1:0]  song;
    logic [8:0]  rom_addr;
    logic [15:0] rom_data;
    logic [17:0] notes_out;
    logic [17:0] durations_out;
    logic [2:0]  voice_valid;
    logic        new_note;
    logic        song_done;
    logic        overflow;

    logic [15:0] rom [0:511];
    chord_t      exp_q[$];
    int          checks = 0;
    int          errors = 0;

    song_reader_poly dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .play          (play),
        .beat          (beat),
        .rewind        (rewind),
        .ff            (ff),
        .song          (song),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .notes_out     (notes_out),
        .durations_out (durations_out),
        .voice_valid   (voice_valid),
        .new_note      (new_note),
        .song_done     (song_done),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic logic [15:0] ent(input logic adv, input int note, input int dur);
        return {adv, note[5:0], dur[5:0], 3'b000};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_chord(input int n2, input int n1, input int n0,
                              input int d2, input int d1, input int d0,
                              input logic [2:0] v);
        chord_t c;
        c.n = {n2[5:0], n1[5:0], n0[5:0]};
        c.d = {d2[5:0], d1[5:0], d0[5:0]};
        c.v = v;
        exp_q.push_back(c);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // which: 0 waits for new_note, 1 waits for song_done
    task automatic wait_for(input string name, input int budget, input bit which);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if ((which ? song_done : new_note) === 1'b1)
                found = 1'b1;
        end
        check(name, {31'd0, found}, 32'd1);
    endtask

    always @(negedge clk) begin : monitor
        chord_t e;
        if (reset_n === 1'b1 && new_note === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL chord_unexpected: got notes 0x%0h valid %b, expected no chord",
                         notes_out, voice_valid);
            end else begin
                e = exp_q.pop_front();
                check("chord_notes", {14'd0, notes_out}, {14'd0, e.n});
                check("chord_durs", {14'd0, durations_out}, {14'd0, e.d});
                check("chord_valid", {29'd0, voice_valid}, {29'd0, e.v});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, expected end of stimulus");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 16'h0000;
        // song 0: four notes into three slots, then a one-beat advance
        rom[0] = ent(0, 1, 1);  rom[1] = ent(0, 2, 2);  rom[2] = ent(0, 3, 3);
        rom[3] = ent(0, 4, 4);  rom[4] = ent(1, 0, 1);  rom[5] = ent(0, 9, 9);
        rom[6] = ent(0, 12, 12);
        // song 1
        rom[128] = ent(0, 10, 8); rom[129] = ent(0, 20, 4); rom[130] = ent(1, 0, 2);
        rom[131] = ent(0, 33, 7); rom[132] = ent(1, 0, 63);
        // song 2: fast-forward scaling and pause material
        rom[256] = ent(0, 7, 3);  rom[257] = ent(0, 8, 0);  rom[258] = ent(1, 0, 0);
        rom[259] = ent(0, 9, 13); rom[260] = ent(1, 0, 8);  rom[261] = ent(1, 0, 5);
        rom[262] = ent(0, 21, 2); rom[263] = ent(1, 0, 63);
        // song 3: zero-length advances to walk the whole region
        for (int i = 384; i < 511; i++) rom[i] = ent(1, 0, 0);
        rom[511] = ent(0, 5, 5);

        reset_n = 1'b0; play = 1'b1; beat = 1'b0; rewind = 1'b0; ff = 1'b0; song = 2'd1;
        tick(); tick();
        check("rst_notes", {14'd0, notes_out}, 32'd0);
        check("rst_durs", {14'd0, durations_out}, 32'd0);
        check("rst_valid", {29'd0, voice_valid}, 32'd0);
        check("rst_new_note", {31'd0, new_note}, 32'd0);
        check("rst_song_done", {31'd0, song_done}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_rom_addr", {23'd0, rom_addr}, 32'd0);

        // chord test on song 1
        push_chord(0, 20, 10, 0, 4, 8, 3'b011);
        reset_n = 1'b1;
        tick();
        check("first_fetch_addr", {23'd0, rom_addr}, 32'd128);
        wait_for("chord_a", 20, 1'b0);
        push_chord(0, 0, 33, 0, 0, 7, 3'b001);
        beat = 1'b1; tick(); beat = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_after_beat1", {31'd0, new_note}, 32'd0);
        end
        beat = 1'b1; tick(); beat = 1'b0;
        check("fetch_after_beat2", {31'd0, new_note}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fetch_after_beat2", {31'd0, new_note}, 32'd0);
        end
        tick();
        check("chord_after_beat2", {31'd0, new_note}, 32'd1);

        // song change 1 -> 0 while parked, then overflow
        song = 2'd0;
        tick();
        check("chg_notes_clear", {14'd0, notes_out}, 32'd0);
        check("chg_durs_clear", {14'd0, durations_out}, 32'd0);
        check("chg_valid_clear", {29'd0, voice_valid}, 32'd0);
        push_chord(3, 2, 1, 3, 2, 1, 3'b111);
        tick();
        check("song0_addr", {23'd0, rom_addr}, 32'd0);
        wait_for("chord_ovf", 20, 1'b0);
        check("overflow_set", {31'd0, overflow}, 32'd1);

        // mid-chord song change 0 -> 2
        beat = 1'b1; tick(); beat = 1'b0;
        tick(); tick();
        song = 2'd2;
        tick();
        check("mid_notes_clear", {14'd0, notes_out}, 32'd0);
        check("mid_valid_clear", {29'd0, voice_valid}, 32'd0);
        check("mid_overflow_clear", {31'd0, overflow}, 32'd0);
        ff = 1'b1;
        push_chord(0, 8, 7, 0, 0, 1, 3'b011);
        push_chord(0, 0, 9, 0, 0, 3, 3'b001);
        tick();
        check("song2_addr", {23'd0, rom_addr}, 32'd256);
        wait_for("chord_ff1", 20, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("adv0_gap", {31'd0, new_note}, 32'd0);
        end
        tick();
        check("adv0_refetch", {31'd0, new_note}, 32'd1);

        // scaled advance of 8 must last exactly two beats
        ff = 1'b0;
        push_chord(0, 0, 0, 0, 0, 0, 3'b000);
        beat = 1'b1; tick(); beat = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ff_cnt_hold", {31'd0, new_note}, 32'd0);
        end
        beat = 1'b1; tick(); beat = 1'b0;
        check("ff_cnt_fetch", {31'd0, new_note}, 32'd0);
        tick();
        check("ff_cnt_fetch", {31'd0, new_note}, 32'd0);
        tick();
        check("ff_cnt_two_beats", {31'd0, new_note}, 32'd1);

        // pause with beats, then resume re-fetches the held pointer
        play = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            beat = 1'b1; tick(); beat = 1'b0; tick();
            check("paused_quiet", {31'd0, new_note}, 32'd0);
        end
        check("pause_ptr", {23'd0, rom_addr}, 32'd262);
        push_chord(0, 0, 21, 0, 0, 2, 3'b001);
        play = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("resume_gap", {31'd0, new_note}, 32'd0);
        end
        tick();
        check("resume_refetch", {31'd0, new_note}, 32'd1);

        // rewind past the start of song 3
        song = 2'd3; rewind = 1'b1;
        push_chord(0, 0, 0, 0, 0, 0, 3'b000);
        wait_for("rewind_end", 20, 1'b1);
        check("rewind_ptr0", {23'd0, rom_addr}, 32'd384);
        tick();
        check("rewind_pulse", {31'd0, song_done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rewind_done_hold", {30'd0, song_done, new_note}, 32'd0);
        end

        // forward walk to the last entry of song 3
        rewind = 1'b0; play = 1'b0;
        tick();
        play = 1'b1;
        for (int i = 0; i < 127; i++) push_chord(0, 0, 0, 0, 0, 0, 3'b000);
        wait_for("forward_end", 400, 1'b1);
        check("forward_ptr0", {23'd0, rom_addr}, 32'd384);
        tick();
        check("forward_pulse", {31'd0, song_done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("forward_done_hold", {30'd0, song_done, new_note}, 32'd0);
        end

        // async reset in the middle of a DECODE cycle
        song = 2'd1;
        push_chord(0, 20, 10, 0, 4, 8, 3'b011);
        wait_for("chord_a_again", 30, 1'b0);
        beat = 1'b1; tick(); tick(); beat = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("async_notes", {14'd0, notes_out}, 32'd0);
        check("async_durs", {14'd0, durations_out}, 32'd0);
        check("async_valid", {29'd0, voice_valid}, 32'd0);
        check("async_rom_addr", {23'd0, rom_addr}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/song_reader_poly.md
Name: song_reader_poly

Overview:
- Parametrised successor to the three-voice song reader.
- Walks a per-song region of an external synchronous song ROM and groups note entries into chords of up to NUM_VOICES voices.
- Emits each chord on an advance entry, then holds it for the advance duration counted in beats.
- Sits between the song ROM and the note players. Supports pause/resume, rewind, fast-forward and song change.

Parameters:
- NUM_VOICES, 3, chord slots per advance.
- NUM_SONGS, 4, songs in ROM (power of 2); SONG_SEL_W = clog2(NUM_SONGS).
- SONG_ADDR_W, 7, entry-address bits per song.
- NOTE_W, 6, note field width.
- DUR_W, 6, duration field width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- play  in  1  run (1) / pause (0).
- beat  in  1  one-cycle beat tick.
- rewind  in  1  step entries backwards; durations scaled.
- ff  in  1  step forwards; durations scaled.
- song  in  SONG_SEL_W  song select.
- rom_addr  out  SONG_SEL_W+SONG_ADDR_W  {song_latched, ptr}.
- rom_data  in  16  valid one cycle after rom_addr. Bit15 = advance flag, [14:9] note, [8:3] duration; [2:0] ignored.
- notes_out  out  NUM_VOICES*NOTE_W  chord notes; voice 0 in LSBs.
- durations_out  out  NUM_VOICES*DUR_W  chord durations.
- voice_valid  out  NUM_VOICES  occupied slots of current chord.
- new_note  out  1  one-cycle pulse when a chord is presented.
- song_done  out  1  one-cycle pulse at end/start of song.
- overflow  out  1  sticky; a note arrived with all slots full. Cleared on song change.

Behaviour:
- Reset values: all outputs 0, ptr 0, state IDLE, song_latched 0, slots cleared, advance counter 0.
- States and transitions:
  - IDLE: latch song. If play, go to FETCH.
  - FETCH: drive rom_addr. Next state is DECODE.
  - DECODE: rom_data is valid here.
    - Note entry: write the next free slot (set its valid bit), step ptr, return to FETCH.
    - Note entry with all slots full: drop the note, set overflow, step ptr, return to FETCH.
    - Advance entry: copy slots to outputs, pulse new_note, clear slots, load counter with the scaled duration, step ptr. Go to ADVANCE, or to FETCH if the scaled duration is 0.
  - ADVANCE: decrement the counter on beat. On a beat with counter==1, go to FETCH.
  - PAUSED: hold ptr, slots, counter and outputs. When play returns, go to FETCH; the current ptr is re-fetched.
  - DONE: hold until play==0, then go to IDLE.
- Pause: play==0 in FETCH, DECODE or ADVANCE forces PAUSED. A DECODE cycle with play==0 discards rom_data without side effects. beat is ignored while paused.
- Stepping: ptr+1 when rewind==0, ptr-1 when rewind==1. ff alone does not change direction.
- Duration scaling: if rewind|ff, the value is dur>>2, floored to 1 when the raw value is nonzero. Otherwise the raw value. Applies to both note and advance durations.
- End of song:
  - Forward step from ptr == 2^SONG_ADDR_W-1, or a rewind step from ptr == 0: pulse song_done, set ptr to 0, clear slots, enter DONE.
  - The output chord is held in DONE.
- Song change: song != song_latched in any non-IDLE state. Next cycle: ptr=0, slots, outputs and overflow cleared, state IDLE. This takes priority over all other events in that cycle.
- Mid-operation reset: asynchronous return to reset values regardless of state.
- All pointer and counter arithmetic is modulo its width; there are no other wrap paths.

Optional Feature:
- SONG_READER_LOOP_EN defined: at end of song, pulse song_done and wrap ptr (forward to 0, rewind to 2^SONG_ADDR_W-1). Go to FETCH instead of DONE; slots are cleared.
- Undefined: behaviour as above (stop in DONE).

Decomposition:
- Package song_reader_pkg holds:
  - state encodings (IDLE, FETCH, DECODE, ADVANCE, PAUSED, DONE; 3 bits);
  - ROM field positions (ADV_BIT=15, NOTE_MSB=14, NOTE_LSB=9, DUR_MSB=8, DUR_LSB=3);
  - the duration-scale shift constant (2).
- Sub-module voice_slot_bank (NUM_VOICES, NOTE_W, DUR_W) contains:
  - the slot registers, valid mask and fill index;
  - load, clear and full/overflow detection.
- The top holds the FSM, ptr, counter and ROM interface.

Test Plan:
- Chord: song 1 with entries {note 10 dur 8, note 20 dur 4, adv dur 2}, play=1 → rom_addr starts at 128. new_note fires with notes_out={0,20,10}, durations_out={0,4,8}, voice_valid=3'b011. The next FETCH occurs after the 2nd beat.
- Overflow: 4 note entries before an advance, NUM_VOICES=3 → the 4th note is dropped, overflow=1, voice_valid=3'b111.
- ff scaling: advance dur 8 with ff=1 → counter loads 2. Note dur 3 → output 1; note dur 0 → output 0, and adv dur 0 goes to FETCH the next cycle.
- Pause/resume: play low mid-ADVANCE with counter 5 and 3 beats applied → counter stays 5. On resume, FETCH re-reads the same ptr.
- End/rewind: ptr=127 forward → song_done pulse, ptr 0, DONE held until play=0. With rewind=1 at ptr 0 → song_done, DONE.
- Song change plus async reset: switch song 0→2 mid-chord → outputs cleared, rom_addr=256 on next FETCH. Asserting reset_n=0 mid-DECODE → all outputs 0 immediately.
